// File: rtl/kbd_scan_seq.sv
// kbd_scan_seq: turns the PS/2 scan-code byte stream into single key events.
// E0 marks an extended code and F0 marks a break; one event is emitted per
// complete sequence, together with live pressed flags for the game keys.
//
// Handshake: din is sampled only in a cycle where din_new = 1. There is no
// back-pressure, so a byte may arrive on every cycle. key_valid and seq_err
// are one-cycle strobes, registered one cycle after the din_new that caused
// them. key_code, key_make and key_repeat hold their values between events.
module kbd_scan_seq #(
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  input  logic       flush,
  output logic       key_valid,
  output logic [8:0] key_code,
  output logic       key_make,
  output logic       key_repeat,
  output logic       seq_err,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic       space_p,
  output logic       enter_p,
  output logic       esc_p,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Last counter value still inside the window; a byte landing on it is accepted.
  localparam logic [21:0] C_LAST = 22'(TIMEOUT_CYC - 1);

  // Pressed-flag bit order.
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SPACE = 4;
  localparam int K_ENTER = 5;
  localparam int K_ESC   = 6;

  state_t      r_state;
  logic [21:0] r_cnt;
  logic [6:0]  r_pressed;
  logic        r_key_valid;
  logic [8:0]  r_key_code;
  logic        r_key_make;
  logic        r_key_repeat;
  logic        r_seq_err;

  state_t      w_next_state;
  logic        w_junk;
  logic        w_ev;
  logic        w_ev_ext;
  logic        w_ev_make;
  logic        w_err;
  logic        w_timeout;
  logic [6:0]  w_hit;
  logic        w_repeat;

  // Bytes that never form part of a key code: ignored in IDLE, errors inside a prefix.
  always_comb begin
    w_junk = (din == 8'h00) || (din == 8'hAA) || (din == 8'hE1) ||
             (din == 8'hFA) || (din == 8'hFE) || (din == 8'hFF);
  end

  // Next-state and event decode; only a din_new cycle moves the sequence, otherwise the timeout is checked.
  always_comb begin
    w_next_state = r_state;
    w_ev         = 1'b0;
    w_ev_ext     = 1'b0;
    w_ev_make    = 1'b0;
    w_err        = 1'b0;
    w_timeout    = 1'b0;
    if (din_new) begin
      case (r_state)
        S_IDLE: begin
          if (din == 8'hE0) begin
            w_next_state = S_EXT;
          end else if (din == 8'hF0) begin
            w_next_state = S_BRK;
          end else if (!w_junk) begin
            w_ev      = 1'b1;
            w_ev_make = 1'b1;
          end
        end
        S_EXT: begin
          if (din == 8'hE0) begin
            w_err        = 1'b1;
            w_next_state = S_EXT;
          end else if (din == 8'hF0) begin
            w_next_state = S_EXT_BRK;
          end else if (w_junk) begin
            w_err        = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_ev         = 1'b1;
            w_ev_ext     = 1'b1;
            w_ev_make    = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          if (din == 8'hE0) begin
            w_err        = 1'b1;
            w_next_state = S_EXT;
          end else if ((din == 8'hF0) || w_junk) begin
            w_err        = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_ev         = 1'b1;
            w_ev_ext     = (r_state == S_EXT_BRK);
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end else if ((r_state != S_IDLE) && (r_cnt == C_LAST)) begin
      w_timeout    = 1'b1;
      w_err        = 1'b1;
      w_next_state = S_IDLE;
    end
  end

  // Map the event's {ext, code} to a one-hot tracked-key vector (all zero for other keys).
  always_comb begin
    w_hit = 7'b0;
    case ({w_ev_ext, din})
      9'h175:  w_hit[K_UP]    = 1'b1;
      9'h172:  w_hit[K_DOWN]  = 1'b1;
      9'h16B:  w_hit[K_LEFT]  = 1'b1;
      9'h174:  w_hit[K_RIGHT] = 1'b1;
      9'h029:  w_hit[K_SPACE] = 1'b1;
      9'h05A:  w_hit[K_ENTER] = 1'b1;
      9'h076:  w_hit[K_ESC]   = 1'b1;
      default: w_hit = 7'b0;
    endcase
    w_repeat = w_ev_make && ((w_hit & r_pressed) != 7'b0);
  end

  // Sequence state and timeout counter; flush forces a clean idle, the counter only runs inside a prefix.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_cnt   <= 22'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 22'd0;
    end else begin
      r_state <= w_next_state;
      if (din_new || (r_state == S_IDLE) || w_timeout) begin
        r_cnt <= 22'd0;
      end else begin
        r_cnt <= r_cnt + 22'd1;
      end
    end
  end

  // Event outputs and pressed flags, registered one cycle after the final byte.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_key_valid  <= 1'b0;
      r_key_code   <= 9'h000;
      r_key_make   <= 1'b0;
      r_key_repeat <= 1'b0;
      r_seq_err    <= 1'b0;
      r_pressed    <= 7'b0;
    end else if (flush) begin
      r_key_valid <= 1'b0;
      r_seq_err   <= 1'b0;
      r_pressed   <= 7'b0;
    end else begin
      r_key_valid <= w_ev;
      r_seq_err   <= w_err;
      if (w_ev) begin
        r_key_code   <= {w_ev_ext, din};
        r_key_make   <= w_ev_make;
        r_key_repeat <= w_repeat;
        if (w_ev_make) begin
          r_pressed <= r_pressed | w_hit;
        end else begin
          r_pressed <= r_pressed & ~w_hit;
        end
      end
    end
  end

  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_make    = r_key_make;
  assign key_repeat  = r_key_repeat;
  assign seq_err     = r_seq_err;
  assign up_p        = r_pressed[K_UP];
  assign down_p      = r_pressed[K_DOWN];
  assign left_p      = r_pressed[K_LEFT];
  assign right_p     = r_pressed[K_RIGHT];
  assign space_p     = r_pressed[K_SPACE];
  assign enter_p     = r_pressed[K_ENTER];
  assign esc_p       = r_pressed[K_ESC];
  assign o_dbg_state = r_state;

endmodule
